board_full: RTL and testbench
=============================

Name: board_full

Overview:
- Registered full-board detector for the 5x5 tic-tac-toe game.
- Samples the 25 two-bit cell codes and asserts is_full when no cell is empty; also reports an occupancy count and an invalid-code flag.
- Sits beside the win checker and feeds the game controller's draw/end-of-game decision.

Parameters:
- N_CELLS, 25, number of board cells (fixed 5x5; only 25 is supported).
- CNT_W, 5, width of occupied_count, equal to $clog2(N_CELLS+1).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- board1..board25  input  2 each  cell codes, row-major (board1 = row0/col0, board25 = row4/col4). 2'b00 = empty, 2'b01 = X, 2'b10 = O, 2'b11 = invalid.
- is_full  output  1  high when all 25 cells are non-empty.
- occupied_count  output  CNT_W  number of non-empty cells, 0..25.
- invalid_cell  output  1  high when any cell holds 2'b11.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset: assertion of rst_n=0 immediately forces is_full=0, occupied_count=0 and invalid_cell=0, independent of clk. Outputs stay at these values while rst_n=0.
- Reset release: the first rising edge of clk with rst_n=1 samples the inputs normally.
- Occupied: a cell is occupied when its code is != 2'b00. Code 2'b11 counts as occupied and also sets invalid_cell.
- Combinational next-state:
  - full_next = AND over all cells of (cell != 0).
  - count_next = popcount of occupied cells, an unsigned sum zero-extended to CNT_W. Maximum is 25, so no overflow.
  - invalid_next = OR over all cells of (cell == 2'b11).
- Registers: all three outputs are flops updated on every rising edge of clk from their next-state values.
  - Latency is exactly one cycle.
  - There is no enable and no handshake; inputs are sampled every cycle.
- Consistency: is_full == (occupied_count == 25) in every cycle.
- Boundaries:
  - 24 occupied cells gives is_full=0 and count=24.
  - A cell returning to 2'b00 drops is_full on the next edge (no sticky behaviour).
  - Mixed X/O occupancy is full.
- Input changes between edges have no effect until the next edge. X/Z on inputs is not required to be handled.

Decomposition:
- Package ttt_pkg:
  - typedef enum logic [1:0] cell_t {CELL_EMPTY=2'b00, CELL_X=2'b01, CELL_O=2'b10, CELL_INV=2'b11}
  - localparam N_CELLS=25 and BOARD_DIM=5.
- board_full packs the 25 inputs into a cell_t array internally.
- Sub-module cell_occupancy_counter: combinational popcount of an N_CELLS-bit occupied vector, producing a CNT_W-bit count. board_full registers its result.

Test Plan:
- Hold rst_n=0 with random cells -> all outputs 0. Release, all cells 0 -> after the edge, is_full=0, occupied_count=0, invalid_cell=0.
- board1..board23=1, board24=board25=0 -> next edge: is_full=0, occupied_count=23. Then board24=board25=1 -> next edge: is_full=1, count=25. Check the output did not change before that edge.
- All cells alternating 1/2 -> is_full=1, count=25, invalid_cell=0. Then clear board13 to 0 -> next edge: is_full=0, count=24.
- Full board with board7=3 -> is_full=1, count=25, invalid_cell=1.
- While is_full=1, assert rst_n=0 mid-cycle -> is_full drops immediately without a clock edge. Deassert -> is_full returns to 1 on the following edge.
- Randomised cells over 1000 cycles -> occupied_count equals the model popcount delayed one cycle, and is_full == (count==25) every cycle.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the 5x5 tic-tac-toe datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ttt_pkg;

    localparam int N_CELLS   = 25;
    localparam int BOARD_DIM = 5;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10,
        CELL_INV   = 2'b11
    } cell_t;

endpackage

// File: rtl/cell_occupancy_counter.sv
// Combinational popcount of an occupied-cell vector.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the result follows its input continuously.
module cell_occupancy_counter #(
    parameter int N_CELLS = 25,
    parameter int CNT_W   = 5
) (
    input  logic [N_CELLS-1:0] occupied,
    output logic [CNT_W-1:0]   count
);

    // Unsigned sum of set bits; CNT_W is wide enough that it never wraps.
    always_comb begin
        count = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            count = count + CNT_W'(occupied[i]);
        end
    end

endmodule

// File: rtl/board_full.sv
// Registered full-board detector: is_full, occupancy count and invalid-code flag.
// Latency: one cycle from board inputs to all three outputs.
// Backpressure: none; inputs are sampled on every rising edge of clk.
module board_full #(
    parameter int N_CELLS = 25,
    parameter int CNT_W   = $clog2(N_CELLS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       board1,
    input  logic [1:0]       board2,
    input  logic [1:0]       board3,
    input  logic [1:0]       board4,
    input  logic [1:0]       board5,
    input  logic [1:0]       board6,
    input  logic [1:0]       board7,
    input  logic [1:0]       board8,
    input  logic [1:0]       board9,
    input  logic [1:0]       board10,
    input  logic [1:0]       board11,
    input  logic [1:0]       board12,
    input  logic [1:0]       board13,
    input  logic [1:0]       board14,
    input  logic [1:0]       board15,
    input  logic [1:0]       board16,
    input  logic [1:0]       board17,
    input  logic [1:0]       board18,
    input  logic [1:0]       board19,
    input  logic [1:0]       board20,
    input  logic [1:0]       board21,
    input  logic [1:0]       board22,
    input  logic [1:0]       board23,
    input  logic [1:0]       board24,
    input  logic [1:0]       board25,
    output logic             is_full,
    output logic [CNT_W-1:0] occupied_count,
    output logic             invalid_cell
);

    import ttt_pkg::*;

    cell_t              cells [N_CELLS];
    logic [N_CELLS-1:0] occupied;
    logic [CNT_W-1:0]   count_d, count_q;
    logic               full_d, full_q;
    logic               inv_d, inv_q;

    // Row-major packing: cells[0] is row0/col0, cells[24] is row4/col4.
    always_comb begin
        cells[0]  = cell_t'(board1);
        cells[1]  = cell_t'(board2);
        cells[2]  = cell_t'(board3);
        cells[3]  = cell_t'(board4);
        cells[4]  = cell_t'(board5);
        cells[5]  = cell_t'(board6);
        cells[6]  = cell_t'(board7);
        cells[7]  = cell_t'(board8);
        cells[8]  = cell_t'(board9);
        cells[9]  = cell_t'(board10);
        cells[10] = cell_t'(board11);
        cells[11] = cell_t'(board12);
        cells[12] = cell_t'(board13);
        cells[13] = cell_t'(board14);
        cells[14] = cell_t'(board15);
        cells[15] = cell_t'(board16);
        cells[16] = cell_t'(board17);
        cells[17] = cell_t'(board18);
        cells[18] = cell_t'(board19);
        cells[19] = cell_t'(board20);
        cells[20] = cell_t'(board21);
        cells[21] = cell_t'(board22);
        cells[22] = cell_t'(board23);
        cells[23] = cell_t'(board24);
        cells[24] = cell_t'(board25);
    end

    // Per-cell classification; the invalid code still counts as occupied.
    always_comb begin
        occupied = '0;
        inv_d    = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            occupied[i] = (cells[i] != CELL_EMPTY);
            inv_d       = inv_d | (cells[i] == CELL_INV);
        end
        full_d = &occupied;
    end

    cell_occupancy_counter #(
        .N_CELLS (N_CELLS),
        .CNT_W   (CNT_W)
    ) u_counter (
        .occupied (occupied),
        .count    (count_d)
    );

    // Output registers, cleared asynchronously while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            count_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            count_q <= count_d;
            inv_q   <= inv_d;
        end
    end

    assign is_full        = full_q;
    assign occupied_count = count_q;
    assign invalid_cell   = inv_q;

endmodule

// File: tb/tb_board_full.sv
module tb_board_full;

    typedef struct {
        logic       full;
        logic [4:0] cnt;
        logic       inv;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] b [25];
    logic       is_full;
    logic [4:0] occupied_count;
    logic       invalid_cell;

    exp_t sb [$];
    int   n_chk;
    int   n_pass;

    board_full dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .board1         (b[0]),
        .board2         (b[1]),
        .board3         (b[2]),
        .board4         (b[3]),
        .board5         (b[4]),
        .board6         (b[5]),
        .board7         (b[6]),
        .board8         (b[7]),
        .board9         (b[8]),
        .board10        (b[9]),
        .board11        (b[10]),
        .board12        (b[11]),
        .board13        (b[12]),
        .board14        (b[13]),
        .board15        (b[14]),
        .board16        (b[15]),
        .board17        (b[16]),
        .board18        (b[17]),
        .board19        (b[18]),
        .board20        (b[19]),
        .board21        (b[20]),
        .board22        (b[21]),
        .board23        (b[22]),
        .board24        (b[23]),
        .board25        (b[24]),
        .is_full        (is_full),
        .occupied_count (occupied_count),
        .invalid_cell   (invalid_cell)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference model of the sampled board.
    function automatic exp_t model();
        exp_t e;
        int   c;
        c     = 0;
        e.inv = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (b[i] != 2'b00) c++;
            if (b[i] == 2'b11) e.inv = 1'b1;
        end
        e.cnt  = 5'(c);
        e.full = (c == 25);
        return e;
    endfunction

    // Push expectation for current inputs, cross one edge, pop and compare.
    task automatic step(input string tag);
        exp_t e;
        sb.push_back(model());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".full"}, int'(is_full), int'(e.full));
        check({tag, ".cnt"},  int'(occupied_count), int'(e.cnt));
        check({tag, ".inv"},  int'(invalid_cell), int'(e.inv));
        check({tag, ".cons"}, int'(is_full), int'(occupied_count == 5'd25));
    endtask

    task automatic set_all(input logic [1:0] v);
        for (int i = 0; i < 25; i++) b[i] = v;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 25; i++) b[i] = 2'($urandom_range(0, 3));

        // Reset held with random cells: outputs stay cleared.
        repeat (3) @(posedge clk);
        #1;
        check("rst.full", int'(is_full), 0);
        check("rst.cnt",  int'(occupied_count), 0);
        check("rst.inv",  int'(invalid_cell), 0);

        // Release with an empty board.
        set_all(2'b00);
        rst_n = 1'b1;
        step("empty");
        check("empty.cnt_abs", int'(occupied_count), 0);

        // 23 occupied, then fill the last two; outputs hold until the edge.
        for (int i = 0; i < 23; i++) b[i] = 2'b01;
        b[23] = 2'b00;
        b[24] = 2'b00;
        step("cnt23");
        check("cnt23.abs", int'(occupied_count), 23);
        b[23] = 2'b01;
        b[24] = 2'b01;
        #2;
        check("hold.full", int'(is_full), 0);
        check("hold.cnt",  int'(occupied_count), 23);
        step("fill25");
        check("fill25.abs", int'(is_full), 1);

        // Mixed X/O is full; then one cell cleared drops is_full.
        for (int i = 0; i < 25; i++) b[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
        step("mixed");
        check("mixed.abs_cnt", int'(occupied_count), 25);
        b[12] = 2'b00;
        step("clr13");
        check("clr13.abs_cnt", int'(occupied_count), 24);
        check("clr13.abs_full", int'(is_full), 0);

        // Full board containing an invalid code.
        b[12] = 2'b10;
        b[6]  = 2'b11;
        step("inv7");
        check("inv7.abs_inv", int'(invalid_cell), 1);
        check("inv7.abs_full", int'(is_full), 1);

        // Asynchronous reset mid-cycle while full.
        b[6] = 2'b01;
        step("prerst");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.full", int'(is_full), 0);
        check("arst.cnt",  int'(occupied_count), 0);
        check("arst.inv",  int'(invalid_cell), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("postrst");
        check("postrst.abs", int'(is_full), 1);

        // Randomised boards biased toward heavy occupancy.
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 39) == 0) b[i] = 2'b00;
                else if ($urandom_range(0, 99) == 0) b[i] = 2'b11;
                else b[i] = 2'($urandom_range(1, 2));
            end
            step("rand");
        end

        check("sb.empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
